// File: rtl/lcd_note_text.sv
// Piano note text source for a 2x16 LCD: key edge capture, 5-note history, char image.
// Optional NOTE_COUNT_EN adds a BCD press counter shown at line 1 columns 14-15.
module lcd_note_text #(
    parameter int unsigned LOCKOUT = 1000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] KEY,
    input  logic [2:0] OCTAVE,
    input  logic [4:0] RD_ADDR,
    output logic [7:0] RD_DATA,
    output logic       UPDATE,
    input  logic       UPDATE_ACK,
    output logic [3:0] CUR_NOTE
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        FLAG
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_INIT = CNT_W'(LOCKOUT);
    localparam logic [CNT_W-1:0] LOCK_ONE  = CNT_W'(1);

    state_t           state;
    logic [7:0]       key_prev;
    logic [CNT_W-1:0] lockout;
    logic [2:0]       pend_idx;
    logic [2:0]       pend_oct;
    logic [2:0]       oct;
    logic [3:0]       hist [5];

    logic [7:0]       new_keys;
    logic [2:0]       press_idx;
    logic [2:0]       disp_oct;
    logic [3:0]       off;
    logic [7:0]       char_next;

`ifdef NOTE_COUNT_EN
    logic [3:0]       cnt_tens;
    logic [3:0]       cnt_units;
`endif

    function automatic logic [7:0] name_hi(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = "D";
            3'd1:    c = "R";
            3'd2:    c = "M";
            3'd3:    c = "F";
            3'd4:    c = "S";
            3'd5:    c = "L";
            3'd6:    c = "S";
            default: c = "D";
        endcase
        return c;
    endfunction

    function automatic logic [7:0] name_lo(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = "O";
            3'd1:    c = "E";
            3'd2:    c = "I";
            3'd3:    c = "A";
            3'd4:    c = "O";
            3'd5:    c = "A";
            3'd6:    c = "I";
            default: c = "O";
        endcase
        return c;
    endfunction

    assign new_keys = KEY & ~key_prev;

    // Scan from the top so the lowest set bit is the last assignment.
    always_comb begin
        press_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (new_keys[i]) begin
                press_idx = 3'(i);
            end
        end
    end

    // High DO belongs to the next octave up, clamped at the top.
    always_comb begin
        disp_oct = oct;
        if (CUR_NOTE[2:0] == 3'd7 && oct != 3'd7) begin
            disp_oct = oct + 3'd1;
        end
    end

    assign off = RD_ADDR[3:0];

    always_comb begin
        char_next = 8'h20;
        if (!RD_ADDR[4]) begin
            case (off)
                4'd0:  char_next = "N";
                4'd1:  char_next = "O";
                4'd2:  char_next = "T";
                4'd3:  char_next = "E";
                4'd5:  char_next = CUR_NOTE[3] ? name_hi(CUR_NOTE[2:0]) : "-";
                4'd6:  char_next = CUR_NOTE[3] ? name_lo(CUR_NOTE[2:0]) : "-";
                4'd9:  char_next = "O";
                4'd10: char_next = "C";
                4'd11: char_next = "T";
                4'd12: char_next = ":";
                4'd13: char_next = 8'h30 + {5'd0, disp_oct};
`ifdef NOTE_COUNT_EN
                4'd14: char_next = 8'h30 + {4'd0, cnt_tens};
                4'd15: char_next = 8'h30 + {4'd0, cnt_units};
`endif
                default: char_next = 8'h20;
            endcase
        end else begin
            // Each entry is three columns; the third column and address 31 stay blank.
            for (int i = 0; i < 5; i++) begin
                if (off == 4'(3 * i)) begin
                    char_next = hist[i][3] ? name_hi(hist[i][2:0]) : "-";
                end else if (off == 4'(3 * i + 1)) begin
                    char_next = hist[i][3] ? name_lo(hist[i][2:0]) : "-";
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state    <= IDLE;
            key_prev <= 8'h00;
            lockout  <= '0;
            pend_idx <= 3'd0;
            pend_oct <= 3'd0;
            oct      <= 3'd0;
            CUR_NOTE <= 4'h0;
            UPDATE   <= 1'b1;
            RD_DATA  <= 8'h20;
            for (int i = 0; i < 5; i++) begin
                hist[i] <= 4'h0;
            end
`ifdef NOTE_COUNT_EN
            cnt_tens  <= 4'd0;
            cnt_units <= 4'd0;
`endif
        end else begin
            key_prev <= KEY;
            RD_DATA  <= char_next;
            if (lockout != '0) begin
                lockout <= lockout - LOCK_ONE;
            end
            if (UPDATE_ACK) begin
                UPDATE <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (new_keys != 8'h00 && lockout == '0) begin
                        pend_idx <= press_idx;
                        pend_oct <= OCTAVE;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    CUR_NOTE <= {1'b1, pend_idx};
                    oct      <= pend_oct;
`ifdef NOTE_COUNT_EN
                    if (cnt_units == 4'd9) begin
                        cnt_units <= 4'd0;
                        cnt_tens  <= (cnt_tens == 4'd9) ? 4'd0 : cnt_tens + 4'd1;
                    end else begin
                        cnt_units <= cnt_units + 4'd1;
                    end
`endif
                    state <= SHIFT;
                end
                SHIFT: begin
                    for (int i = 4; i > 0; i--) begin
                        hist[i] <= hist[i-1];
                    end
                    hist[0] <= CUR_NOTE;
                    state   <= FLAG;
                end
                FLAG: begin
                    // Overrides a coincident acknowledge so the change is not lost.
                    UPDATE  <= 1'b1;
                    lockout <= LOCK_INIT;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_note_text.sv
// Bench for lcd_note_text: reset image table, directed corner cases,
// and random key/ack/reset traffic against an event-level reference model.
module tb_lcd_note_text;

    localparam int L = 4;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [7:0] KEY = 8'h00;
    logic [2:0] OCTAVE = 3'd0;
    logic [4:0] RD_ADDR = 5'd0;
    logic [7:0] RD_DATA;
    logic       UPDATE;
    logic       UPDATE_ACK = 1'b0;
    logic [3:0] CUR_NOTE;

    lcd_note_text #(.LOCKOUT(L), .CNT_W(16)) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .KEY(KEY),
        .OCTAVE(OCTAVE),
        .RD_ADDR(RD_ADDR),
        .RD_DATA(RD_DATA),
        .UPDATE(UPDATE),
        .UPDATE_ACK(UPDATE_ACK),
        .CUR_NOTE(CUR_NOTE)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    string names [8] = '{"DO", "RE", "MI", "FA", "SO", "LA", "SI", "DO"};

    // Reference model: events are scheduled by cycle number.
    int         cyc = 0;
    logic [7:0] m_prev = 8'h00;
    int         m_hist [$];
    logic       m_cv = 1'b0;
    logic [2:0] m_ci = 3'd0;
    int         m_oct = 0;
    logic       m_upd = 1'b1;
    int         m_cnt = 0;
    int         m_pc = -100;
    int         m_pi = 0;
    int         m_po = 0;
    int         m_ready = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic string model_img();
        string s;
        int d;
        d = m_oct;
        if (m_cv && m_ci == 3'd7 && d < 7) d++;
        s = {"NOTE ", (m_cv ? names[m_ci] : "--"), "  OCT:", $sformatf("%0d", d)};
`ifdef NOTE_COUNT_EN
        s = {s, $sformatf("%02d", m_cnt)};
`else
        s = {s, "  "};
`endif
        for (int i = 0; i < 5; i++) begin
            if (i < m_hist.size()) s = {s, names[m_hist[i]], " "};
            else s = {s, "-- "};
        end
        s = {s, " "};
        return s;
    endfunction

    task automatic model_edge();
        logic [7:0] nw;
        if (!RESETN) begin
            m_prev = 8'h00;
            m_hist.delete();
            m_cv = 1'b0;
            m_ci = 3'd0;
            m_oct = 0;
            m_upd = 1'b1;
            m_cnt = 0;
            m_pc = -100;
            m_ready = cyc + 1;
        end else begin
            nw = KEY & ~m_prev;
            m_prev = KEY;
            if (cyc >= m_ready && nw != 8'h00) begin
                for (int i = 7; i >= 0; i--) if (nw[i]) m_pi = i;
                m_pc = cyc;
                m_po = int'(OCTAVE);
                m_ready = cyc + 4 + L;
            end
            if (cyc == m_pc + 1) begin
                m_cv = 1'b1;
                m_ci = 3'(m_pi);
                m_oct = m_po;
                m_cnt = (m_cnt + 1) % 100;
            end
            if (cyc == m_pc + 2) begin
                m_hist.push_front(m_pi);
                if (m_hist.size() > 5) void'(m_hist.pop_back());
            end
            if (cyc == m_pc + 3) m_upd = 1'b1;
            else if (UPDATE_ACK) m_upd = 1'b0;
        end
    endtask

    task automatic tick();
        string img;
        logic [7:0] exp_rd;
        img = model_img();
        exp_rd = RESETN ? img[RD_ADDR] : 8'h20;
        @(posedge CLK);
        cyc++;
        model_edge();
        #1;
        check("rd_data", RD_DATA, exp_rd);
        check("cur_note", CUR_NOTE, {m_cv, m_ci});
        check("update", UPDATE, m_upd);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        RD_ADDR = a;
        tick();
        d = RD_DATA;
    endtask

    task automatic ack();
        UPDATE_ACK = 1'b1;
        tick();
        UPDATE_ACK = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        KEY = k;
        tick();
        KEY = 8'h00;
        idle(L + 4);
    endtask

    typedef struct {
        logic [4:0] addr;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [32];

    initial begin
        string exp_s;
        string l2;
        logic [7:0] d;

`ifdef NOTE_COUNT_EN
        exp_s = {"NOTE --  OCT:000", "-- -- -- -- -- ", " "};
`else
        exp_s = {"NOTE --  OCT:0  ", "-- -- -- -- -- ", " "};
`endif
        for (int i = 0; i < 32; i++) begin
            tbl[i].addr = 5'(i);
            tbl[i].exp = exp_s[i];
        end

        idle(3);
        RESETN = 1'b1;

        for (int i = 0; i < 32; i++) begin
            RD_ADDR = tbl[i].addr;
            tick();
            check($sformatf("reset_img[%0d]", i), RD_DATA, tbl[i].exp);
        end
        check("reset_update", UPDATE, 1);
        ack();
        check("ack_clear", UPDATE, 0);

        // Held SO key: one event, UPDATE three cycles after the edge.
        OCTAVE = 3'd3;
        KEY = 8'h10;
        tick();
        tick();
        check("so_cur", CUR_NOTE, 4'hC);
        tick();
        check("so_update_early", UPDATE, 0);
        tick();
        check("so_update_lat", UPDATE, 1);
        idle(6);
        KEY = 8'h00;
        rd(5'd5, d);  check("so_name_hi", d, 8'h53);
        rd(5'd6, d);  check("so_name_lo", d, 8'h4F);
        rd(5'd13, d); check("so_oct", d, 8'h33);
        rd(5'd16, d); check("so_hist0", d, "S");
        rd(5'd19, d); check("so_single_event", d, "-");

        // Simultaneous RE+MI edge: lowest wins, MI needs a fresh edge.
        ack();
        idle(L + 2);
        KEY = 8'h06;
        idle(4);
        check("re_cur", CUR_NOTE, 4'h9);
        rd(5'd16, d); check("re_hist0", d, "R");
        rd(5'd19, d); check("re_hist1", d, "S");
        idle(L + 2);
        check("re_held_no_mi", CUR_NOTE, 4'h9);
        KEY = 8'h02;
        tick();
        KEY = 8'h06;
        idle(4);
        check("mi_repress", CUR_NOTE, 4'hA);
        rd(5'd16, d); check("mi_hist0", d, "M");

        // Reset while a capture is in flight.
        KEY = 8'h00;
        idle(L + 2);
        KEY = 8'h08;
        tick();
        tick();
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        KEY = 8'h00;
        idle(3);
        check("rst_mid_cur", CUR_NOTE, 4'h0);
        check("rst_mid_update", UPDATE, 1);
        rd(5'd16, d); check("rst_mid_hist", d, "-");

        // Six presses: the oldest falls off the end.
        for (int k = 0; k < 6; k++) press(8'(1 << k));
        l2 = "LA SO FA MI RE  ";
        for (int i = 0; i < 16; i++) begin
            rd(5'(16 + i), d);
            check($sformatf("line2[%0d]", i), d, l2[i]);
        end

        // Press inside the lockout window is ignored.
        ack();
        KEY = 8'h01;
        tick();
        KEY = 8'h00;
        idle(4);
        KEY = 8'h02;
        tick();
        KEY = 8'h00;
        idle(L + 4);
        check("lockout_cur", CUR_NOTE, 4'h8);
        rd(5'd16, d); check("lockout_hist0", d, "D");
        rd(5'd19, d); check("lockout_hist1", d, "L");

        // FLAG coincident with acknowledge keeps UPDATE set.
        ack();
        KEY = 8'h04;
        tick();
        KEY = 8'h00;
        tick();
        tick();
        UPDATE_ACK = 1'b1;
        tick();
        UPDATE_ACK = 1'b0;
        check("flag_ack_wins", UPDATE, 1);
        tick();
        check("flag_ack_hold", UPDATE, 1);
        ack();
        check("flag_ack_later_clear", UPDATE, 0);

        // High DO shows the next octave, clamped at 7.
        OCTAVE = 3'd7;
        idle(L);
        press(8'h80);
        rd(5'd13, d); check("hi_do_oct_sat", d, "7");
        rd(5'd5, d);  check("hi_do_name", d, "D");
        OCTAVE = 3'd2;
        press(8'h80);
        rd(5'd13, d); check("hi_do_oct_inc", d, "3");

`ifdef NOTE_COUNT_EN
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        for (int i = 0; i < 100; i++) press(8'h01);
        rd(5'd14, d); check("cnt100_tens", d, "0");
        rd(5'd15, d); check("cnt100_units", d, "0");
        press(8'h01);
        rd(5'd14, d); check("cnt101_tens", d, "0");
        rd(5'd15, d); check("cnt101_units", d, "1");
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) KEY = 8'($urandom);
            if ($urandom_range(0, 15) == 0) OCTAVE = 3'($urandom);
            RD_ADDR = 5'($urandom);
            UPDATE_ACK = ($urandom_range(0, 7) == 0);
            RESETN = ($urandom_range(0, 399) != 0);
            tick();
        end
        RESETN = 1'b1;
        UPDATE_ACK = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_note_text.md
Name: lcd_note_text

Overview:
- Upstream text source for the 2x16 character LCD controller in the electronic piano.
- Detects piano key presses and latches the current note and octave.
- Keeps a 5-entry history of played notes.
- Serves a 32-byte character image (line 1: addresses 0-15, line 2: addresses 16-31) through a registered read port.
- Raises an update handshake whenever the image changes, so the LCD controller redraws only when needed.

Parameters:
- LOCKOUT, 16'd1000: cycles after an accepted press during which new presses are ignored (debounce). Value 0 disables the lockout.
- CNT_W, 16: width of the lockout counter.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  reset, synchronous, active-low.
- KEY  in  8  piano keys, level, active-high. 0=DO, 1=RE, 2=MI, 3=FA, 4=SO, 5=LA, 6=SI, 7=high DO.
- OCTAVE  in  3  current octave 0-7, sampled at press acceptance.
- RD_ADDR  in  5  character address from the LCD controller.
- RD_DATA  out  8  ASCII character at RD_ADDR, valid 1 cycle after the address.
- UPDATE  out  1  image changed since the last acknowledge.
- UPDATE_ACK  in  1  one-cycle pulse from the LCD controller when a redraw starts.
- CUR_NOTE  out  4  bit3 = valid, bits2:0 = last accepted key index.

Behaviour:
- Reset (RESETN=0 at a CLK edge):
  - KEY_prev=0, FSM=IDLE, lockout counter=0, history entries all empty.
  - CUR_NOTE=4'h0, latched octave=0, RD_DATA=8'h20.
  - UPDATE=1, which forces an initial draw.
  - Reset mid-sequence discards any pending capture.
- Edge detect:
  - new = KEY & ~KEY_prev. KEY_prev is registered every cycle, including during lockout.
  - Holding a key therefore produces exactly one event.
- Priority: if several bits of new are set, the lowest index wins. The other bits are dropped for good, because KEY_prev already records them.
- FSM:
  - IDLE: if new!=0 and lockout==0, go to CAPTURE.
  - CAPTURE: latch key index and OCTAVE, set CUR_NOTE valid. Go to SHIFT.
  - SHIFT: hist[4]<=hist[3], ..., hist[1]<=hist[0], hist[0]<=new note. Go to FLAG.
  - FLAG: UPDATE<=1, lockout<=LOCKOUT. Go to IDLE.
  - Press-to-UPDATE latency is 3 cycles after the edge cycle.
- Lockout: decrements by 1 each cycle while nonzero and saturates at 0. A press seen while lockout>0 is ignored.
- UPDATE:
  - Cleared when UPDATE_ACK=1 and the FSM is not in FLAG.
  - If FLAG and UPDATE_ACK occur in the same cycle, UPDATE stays 1 (the change wins).
- Line 1 image:
  - 0-4: "NOTE ".
  - 5-6: note name; "--" if there is no valid note.
  - 7-8: spaces.
  - 9-12: "OCT:".
  - 13: '0'+octave. Key 7 shows octave+1, saturating at 7.
  - 14-15: spaces (see optional feature).
- Line 2 image:
  - Entry i occupies addresses 16+3i..18+3i as two name characters plus a space.
  - Empty entry shows "-- ".
  - Address 31 is a space.
  - Newest entry is leftmost.
- Names: DO RE MI FA SO LA SI DO (key 7 also shows "DO").
- RD_DATA is combinationally decoded from the state and registered once. An image change is visible on RD_DATA 1 cycle after the state changes.

Optional Feature:
- Macro: NOTE_COUNT_EN.
- Defined:
  - A 2-digit BCD counter counts accepted presses and wraps 99->00.
  - Addresses 14-15 show the tens digit and units digit as ASCII.
  - Reset value is 00; the counter increments in CAPTURE.
- Undefined: no counter logic is built, and addresses 14-15 are 8'h20.

Test Plan:
- Reset, then read addresses 0-31:
  - Line 1 reads "NOTE --  OCT:0  ".
  - Line 2 reads "-- " x5 followed by a space.
  - UPDATE=1.
  - Pulse UPDATE_ACK: UPDATE drops to 0 the next cycle.
- LOCKOUT=4, OCTAVE=3, KEY=8'h10 held 10 cycles:
  - Exactly one event.
  - Addresses 5-6 = 0x53,0x4F ("SO"); address 13 = 0x33.
  - Address 16 = 'S'; CUR_NOTE=4'hC.
  - UPDATE rises 3 cycles after the edge.
- KEY=8'h06 rising in the same cycle: only RE is recorded. A later release and re-press of bit 2 is accepted after lockout.
- Press keys 0,1,2,3,4,5 in turn, spaced beyond lockout: line 2 reads "LA SO FA MI RE " (DO is shifted out).
- Second press inside the lockout window: ignored, history unchanged. FLAG coincident with UPDATE_ACK: UPDATE stays 1.
- With NOTE_COUNT_EN defined, 100 presses: addresses 14-15 read "00". After press 101 they read "01".
